slt32_cmp: RTL and testbench

SLT32_CMP -- requirements
Module: slt32

---
 rtl/slt32_cmp_pkg.sv | 12 +
 rtl/slt32_cmp_if.sv | 26 ++
 rtl/slt32_cmp.sv | 59 +++++
 tb/tb_slt32_cmp.sv | 122 ++++++++++++
 4 files changed

// File: rtl/slt32_cmp_pkg.sv
// Shared ALU constants for the set-less-than compare stage: operand width and
// result encoding of the zero-extended slt bit.
package slt32_cmp_pkg;

  localparam int unsigned SLT_WIDTH = 32;

  typedef enum logic {
    RES_GE = 1'b0,
    RES_LT = 1'b1
  } slt_res_e;

endpackage

// File: rtl/slt32_cmp_if.sv
// Operand/result bundle between the host ALU and the registered signed compare.
interface slt32_cmp_if
  import slt32_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = SLT_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             in_valid;
  logic             slt;
  logic             s_err;
  logic             out_valid;

  modport master (
    output A, B, S, in_valid,
    input  slt, s_err, out_valid
  );

  modport slave (
    input  A, B, S, in_valid,
    output slt, s_err, out_valid
  );

endinterface

// File: rtl/slt32_cmp.sv
// Registered signed less-than with a cross-check of the host adder's A-B.
// One-cycle latency, one result per cycle, results held while idle.
module slt32_cmp
  import slt32_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = SLT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  slt32_cmp_if.slave  bus
);

  logic [WIDTH:0] diff;
  slt_res_e       lt_next;
  logic           err_next;

  logic slt_d,       slt_q;
  logic s_err_d,     s_err_q;
  logic out_valid_d, out_valid_q;

  // Sign-extending to WIDTH+1 bits makes the top bit of the difference the
  // true signed comparison, with overflow already folded in.
  always_comb begin
    diff     = {bus.A[WIDTH-1], bus.A} - {bus.B[WIDTH-1], bus.B};
    lt_next  = diff[WIDTH] ? RES_LT : RES_GE;
    err_next = (bus.S != diff[WIDTH-1:0]);
  end

  always_comb begin
    slt_d       = slt_q;
    s_err_d     = s_err_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      slt_d       = lt_next;
      s_err_d     = err_next;
      out_valid_d = 1'b1;
    end
  end

  // NOTE: non-blocking assignments in clocked logic so every flop samples the
  // pre-edge value; the reset branch is in the sensitivity list, making the
  // clear take effect without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slt_q       <= 1'b0;
      s_err_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      slt_q       <= slt_d;
      s_err_q     <= s_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.slt       = slt_q;
  assign bus.s_err     = s_err_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_slt32_cmp.sv
// Self-checking bench for slt32_cmp: directed corner cases, hold/reset
// behaviour, then randomized traffic against a signed-arithmetic model.
module tb_slt32_cmp;
  import slt32_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic       exp_slt, exp_err, exp_ov;

  always #5 clk = ~clk;

  slt32_cmp_if #(.WIDTH(32)) bus ();

  slt32_cmp #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".slt"},       {31'd0, bus.slt},       {31'd0, exp_slt});
    check({tag, ".s_err"},     {31'd0, bus.s_err},     {31'd0, exp_err});
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_ov});
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] s, input logic v);
    bus.A        = a;
    bus.B        = b;
    bus.S        = s;
    bus.in_valid = v;
    if (v) begin
      exp_slt = ($signed(a) < $signed(b));
      exp_err = (s != a - b);
      exp_ov  = 1'b1;
    end else begin
      exp_ov  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb, rs;
    logic        rv;

    rst          = 1'b1;
    bus.A        = '0;
    bus.B        = '0;
    bus.S        = '0;
    bus.in_valid = 1'b0;
    exp_slt = 1'b0; exp_err = 1'b0; exp_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step(32'd5, 32'd9, 32'hFFFF_FFFC, 1'b1);              check_all("5_lt_9");
    step(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1); check_all("min_lt_max");
    step(32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); check_all("max_vs_min");
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);        check_all("m1_eq_m1");
    step(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1);        check_all("m1_lt_1");
    step(32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1);        check_all("min_eq_min");
    step(32'd3, 32'd2, 32'd5, 1'b1);                        check_all("wrong_s");
    check("wrong_s.err_set", {31'd0, bus.s_err}, 32'd1);

    // Pulse with slt=1 then three idle cycles: outputs hold, out_valid drops.
    step(32'hFFFF_FFF0, 32'd7, 32'd1234, 1'b1);             check_all("pulse");
    for (int i = 0; i < 3; i++) begin
      step($urandom, $urandom, $urandom, 1'b0);             check_all("hold");
    end
    check("hold.slt_kept", {31'd0, bus.slt}, 32'd1);

    // Asynchronous reset between edges while slt=1.
    step(32'h8000_0001, 32'd0, 32'h0, 1'b1);                check_all("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    exp_slt = 1'b0; exp_err = 1'b0; exp_ov = 1'b0;
    check_all("async_rst");
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_held_edge");
    @(negedge clk);
    rst = 1'b0;
    step(32'd1, 32'd2, 32'h0, 1'b0);                        check_all("post_rst_idle");
    step(32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1);                check_all("post_rst_first");

    // Randomized back-to-back traffic, biased toward equal and boundary operands.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = ra;
        1:       rb = ra ^ 32'h8000_0000;
        2:       rb = ra + 32'd1;
        default: rb = $urandom;
      endcase
      rs = ($urandom_range(0, 3) == 0) ? $urandom : ra - rb;
      rv = ($urandom_range(0, 4) != 0);
      step(ra, rb, rs, rv);
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
